add_share_arbiter: RTL and testbench



---
 rtl/add_share_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_add_share_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: round-robin sequencer that shares one external signed
// adder between two requesters. Each requester hands over an operand pair
// (valid/ready) and gets back an 8-bit sign-extended sum (valid/ack).
// Optional feature: define ADD_SHARE_OVF_EN to add per-requester overflow
// flags (rsp0_ovf / rsp1_ovf) registered alongside the result.
module add_share_arbiter #(
   parameter int SIZE = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic [SIZE-1:0] req0_x,
   input  logic [SIZE-1:0] req0_y,
   output logic            req0_ready,
   output logic            rsp0_valid,
   output logic [7:0]      rsp0_sum,
   input  logic            rsp0_ack,
   input  logic            req1_valid,
   input  logic [SIZE-1:0] req1_x,
   input  logic [SIZE-1:0] req1_y,
   output logic            req1_ready,
   output logic            rsp1_valid,
   output logic [7:0]      rsp1_sum,
   input  logic            rsp1_ack,
   output logic [SIZE-1:0] add_x,
   output logic [SIZE-1:0] add_y,
   input  logic [7:0]      add_s,
   output logic            busy
`ifdef ADD_SHARE_OVF_EN
   ,
   output logic            rsp0_ovf,
   output logic            rsp1_ovf
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]      state_r;
   logic [1:0]      next_state_s;
   logic            last_r;        // id of the requester granted most recently
   logic            grant_r;       // id of the requester currently being served
   logic [SIZE-1:0] opx_r;
   logic [SIZE-1:0] opy_r;
   logic [7:0]      res_r;
`ifdef ADD_SHARE_OVF_EN
   logic            ovf_r;
`endif

   logic            any_valid_s;
   logic            winner_s;
   logic            accept_s;
   logic            ack_s;

   // Round-robin winner: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      any_valid_s = req0_valid | req1_valid;
      if (req0_valid & req1_valid) begin
         winner_s = ~last_r;
      end else if (req1_valid) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
   end

   // Handshake decode: accept only from IDLE; only the served requester's ack counts.
   always_comb begin
      accept_s = (state_r == IDLE) & any_valid_s;
      if (grant_r) begin
         ack_s = rsp1_ack;
      end else begin
         ack_s = rsp0_ack;
      end
   end

   // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               next_state_s = EXEC;
            end else begin
               next_state_s = IDLE;
            end
         end
         EXEC: begin
            next_state_s = RESP;
         end
         RESP: begin
            if (ack_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RESP;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State register; an unknown encoding recovers to IDLE through the default arm.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Grant bookkeeping: record the winner on accept, commit it as last-granted on ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_r <= 1'b0;
         last_r  <= 1'b1;
      end else begin
         if (accept_s) begin
            grant_r <= winner_s;
         end
         if ((state_r == RESP) && ack_s) begin
            last_r <= grant_r;
         end
      end
   end

   // Operand capture on accept; held afterwards so the adder inputs never float.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opx_r <= {SIZE{1'b0}};
         opy_r <= {SIZE{1'b0}};
      end else if (accept_s) begin
         if (winner_s) begin
            opx_r <= req1_x;
            opy_r <= req1_y;
         end else begin
            opx_r <= req0_x;
            opy_r <= req0_y;
         end
      end
   end

   // Result capture at the end of EXEC, when the adder output reflects the latched operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_r <= 8'h00;
`ifdef ADD_SHARE_OVF_EN
         ovf_r <= 1'b0;
`endif
      end else if (state_r == EXEC) begin
         res_r <= add_s;
`ifdef ADD_SHARE_OVF_EN
         // The top two significant sum bits disagree when the sum needs SIZE+1 bits.
         ovf_r <= add_s[SIZE] ^ add_s[SIZE-1];
`endif
      end
   end

   // Output decode from registered state; the idle requester always sees a zero sum.
   always_comb begin
      add_x      = opx_r;
      add_y      = opy_r;
      busy       = (state_r != IDLE);
      req0_ready = accept_s & ~winner_s;
      req1_ready = accept_s & winner_s;
      rsp0_valid = (state_r == RESP) & ~grant_r;
      rsp1_valid = (state_r == RESP) & grant_r;
      if (rsp0_valid) begin
         rsp0_sum = res_r;
      end else begin
         rsp0_sum = 8'h00;
      end
      if (rsp1_valid) begin
         rsp1_sum = res_r;
      end else begin
         rsp1_sum = 8'h00;
      end
`ifdef ADD_SHARE_OVF_EN
      rsp0_ovf = rsp0_valid & ovf_r;
      rsp1_ovf = rsp1_valid & ovf_r;
`endif
   end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Self-checking bench for add_share_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a transaction-level model.
// Overflow flags are checked only when ADD_SHARE_OVF_EN is defined.
module tb_add_share_arbiter;

   localparam int SIZE = 4;

   logic            clk;
   logic            rst;
   logic            req0_valid, req1_valid;
   logic [SIZE-1:0] req0_x, req0_y, req1_x, req1_y;
   logic            req0_ready, req1_ready;
   logic            rsp0_valid, rsp1_valid;
   logic [7:0]      rsp0_sum, rsp1_sum;
   logic            rsp0_ack, rsp1_ack;
   logic [SIZE-1:0] add_x, add_y;
   logic [7:0]      add_s;
   logic            busy;
   logic            rsp0_ovf, rsp1_ovf;

   // Behavioural shared adder: sign-extend both operands and add in 8 bits.
   logic signed [7:0] ax, ay;
   assign ax    = $signed(add_x);
   assign ay    = $signed(add_y);
   assign add_s = ax + ay;

   add_share_arbiter #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_ack(rsp0_ack),
      .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_ack(rsp1_ack),
      .add_x(add_x), .add_y(add_y), .add_s(add_s),
`ifdef ADD_SHARE_OVF_EN
      .rsp0_ovf(rsp0_ovf), .rsp1_ovf(rsp1_ovf),
`endif
      .busy(busy)
   );

`ifndef ADD_SHARE_OVF_EN
   assign rsp0_ovf = 1'b0;
   assign rsp1_ovf = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_ovf(input string name, input logic act, input logic exp);
`ifdef ADD_SHARE_OVF_EN
      check(name, {31'd0, act}, {31'd0, exp});
`endif
   endtask

   typedef struct {
      logic            v0;
      logic [SIZE-1:0] x0, y0;
      logic            v1;
      logic [SIZE-1:0] x1, y1;
      logic            g;    // expected grant
      logic [7:0]      sum;  // expected response sum
      logic            ovf;  // expected overflow flag
   } vec_t;

   vec_t tbl[7];

   // One full transaction with both acks high; starts and ends at a negedge in IDLE.
   task automatic run_txn(input vec_t v);
      req0_valid = v.v0; req0_x = v.x0; req0_y = v.y0;
      req1_valid = v.v1; req1_x = v.x1; req1_y = v.y1;
      rsp0_ack = 1'b1; rsp1_ack = 1'b1;
      #1;
      check("idle_ready0", req0_ready, !v.g);
      check("idle_ready1", req1_ready, v.g);
      check("idle_busy", busy, 1'b0);
      @(posedge clk); @(negedge clk);
      check("exec_busy", busy, 1'b1);
      check("exec_ready0", req0_ready, 1'b0);
      check("exec_ready1", req1_ready, 1'b0);
      check("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      check("exec_add_x", add_x, v.g ? v.x1 : v.x0);
      check("exec_add_y", add_y, v.g ? v.y1 : v.y0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("resp_valid0", rsp0_valid, !v.g);
      check("resp_valid1", rsp1_valid, v.g);
      check("resp_sum0", rsp0_sum, v.g ? 8'h00 : v.sum);
      check("resp_sum1", rsp1_sum, v.g ? v.sum : 8'h00);
      check_ovf("resp_ovf0", rsp0_ovf, v.g ? 1'b0 : v.ovf);
      check_ovf("resp_ovf1", rsp1_ovf, v.g ? v.ovf : 1'b0);
      @(posedge clk); @(negedge clk);
      check("post_busy", busy, 1'b0);
      check("post_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      check_ovf("post_ovf0", rsp0_ovf, 1'b0);
   endtask

   // Reference model state (transaction level).
   bit              m_active, m_last, m_g;
   int              m_age;
   logic [7:0]      m_sum;
   bit              m_ovf;
   logic [SIZE-1:0] m_x, m_y;

   function automatic int sval(input logic [SIZE-1:0] v);
      return int'(v) - (v[SIZE-1] ? (1 << SIZE) : 0);
   endfunction

   initial begin
      vec_t v;
      int   sx, sy;
      bit   w, r0, r1, rv0, rv1;

      // g, sum and ovf are worked out by hand from the round-robin rule and signed addition.
      tbl[0] = '{1'b1, 4'd7,  4'd1,  1'b0, 4'd0,  4'd0,  1'b0, 8'h08, 1'b1}; // 7+1
      tbl[1] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'h8,  4'hF,  1'b1, 8'hF7, 1'b1}; // -8+-1
      tbl[2] = '{1'b1, 4'd3,  4'd2,  1'b1, 4'd3,  4'd2,  1'b0, 8'h05, 1'b0}; // tie -> 0
      tbl[3] = '{1'b1, 4'd3,  4'd2,  1'b1, 4'd3,  4'd2,  1'b1, 8'h05, 1'b0}; // tie -> 1
      tbl[4] = '{1'b1, 4'd3,  4'd2,  1'b1, 4'd3,  4'd2,  1'b0, 8'h05, 1'b0}; // tie -> 0
      tbl[5] = '{1'b1, 4'hC,  4'd3,  1'b0, 4'd0,  4'd0,  1'b0, 8'hFF, 1'b0}; // -4+3
      tbl[6] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd5,  4'd6,  1'b1, 8'h0B, 1'b1}; // 5+6

      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
      rsp0_ack = 1'b0; rsp1_ack = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_add_x", add_x, 4'd0);
      check("rst_add_y", add_y, 4'd0);
      check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      check("rst_rsp_sum", {rsp1_sum, rsp0_sum}, 16'h0000);
      check("rst_ready", {req1_ready, req0_ready}, 2'b00);
      check_ovf("rst_ovf", rsp0_ovf | rsp1_ovf, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_txn(tbl[i]);

      // Ack withheld 5 cycles, with a stray ack from the non-granted requester.
      req0_valid = 1'b1; req0_x = 4'd3; req0_y = 4'd2;
      rsp0_ack = 1'b0; rsp1_ack = 1'b0;
      #1 check("hold_accept", req0_ready, 1'b1);
      @(posedge clk); @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b1; req1_x = 4'd1; req1_y = 4'd1;
      #1 check("hold_exec_ready1", req1_ready, 1'b0);
      @(posedge clk); @(negedge clk);
      rsp1_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold_valid0", rsp0_valid, 1'b1);
         check("hold_sum0", rsp0_sum, 8'h05);
         check("hold_busy", busy, 1'b1);
         check("hold_ready1", req1_ready, 1'b0);
         @(negedge clk);
      end
      rsp1_ack = 1'b0; rsp0_ack = 1'b1;
      #1 check("hold_valid_before_edge", rsp0_valid, 1'b1);
      @(posedge clk); @(negedge clk);
      rsp0_ack = 1'b0;
      #1;
      check("after_ack_valid0", rsp0_valid, 1'b0);
      check("after_ack_ready1", req1_ready, 1'b1);
      @(posedge clk); @(negedge clk);
      req1_valid = 1'b0;
      check("r1_exec_add_x", add_x, 4'd1);
      @(posedge clk); @(negedge clk);
      check("r1_valid", rsp1_valid, 1'b1);
      check("r1_sum", rsp1_sum, 8'h02);
      rsp1_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp1_ack = 1'b0;
      check("r1_done_busy", busy, 1'b0);

      // Make requester 0 last-granted, so a tie now favours requester 1.
      v = '{1'b1, 4'd2, 4'd2, 1'b0, 4'd0, 4'd0, 1'b0, 8'h04, 1'b0};
      run_txn(v);

      // Reset mid-EXEC: result is lost and the round-robin pointer returns to its reset value.
      req0_valid = 1'b1; req0_x = 4'd1; req0_y = 4'd1;
      req1_valid = 1'b1; req1_x = 4'd2; req1_y = 4'd2;
      #1 check("pre_rst_ready1", req1_ready, 1'b1);
      @(posedge clk); @(negedge clk);
      check("pre_rst_busy", busy, 1'b1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_add_x", add_x, 4'd0);
      check("async_rst_add_y", add_y, 4'd0);
      check("async_rst_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_resp_after_rst", {rsp1_valid, rsp0_valid, busy}, 3'b000);
      end
      v = '{1'b1, 4'd3, 4'd2, 1'b1, 4'd3, 4'd2, 1'b0, 8'h05, 1'b0};
      run_txn(v);

      // Randomized traffic against the transaction-level model.
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      m_active = 1'b0; m_last = 1'b1; m_age = 0; m_g = 1'b0; m_sum = 8'h00; m_ovf = 1'b0;
      for (int c = 0; c < 400; c++) begin
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_x = SIZE'($urandom); req0_y = SIZE'($urandom);
         req1_x = SIZE'($urandom); req1_y = SIZE'($urandom);
         rsp0_ack = ($urandom_range(0, 2) != 0);
         rsp1_ack = ($urandom_range(0, 2) != 0);
         #1;
         if (req0_valid && req1_valid) w = !m_last;
         else                          w = req1_valid;
         r0  = !m_active && (req0_valid || req1_valid) && !w;
         r1  = !m_active && (req0_valid || req1_valid) && w;
         rv0 = m_active && (m_age >= 1) && !m_g;
         rv1 = m_active && (m_age >= 1) && m_g;
         check("rnd_ready0", req0_ready, r0);
         check("rnd_ready1", req1_ready, r1);
         check("rnd_valid0", rsp0_valid, rv0);
         check("rnd_valid1", rsp1_valid, rv1);
         check("rnd_sum0", rsp0_sum, rv0 ? m_sum : 8'h00);
         check("rnd_sum1", rsp1_sum, rv1 ? m_sum : 8'h00);
         check("rnd_busy", busy, m_active);
         check_ovf("rnd_ovf0", rsp0_ovf, rv0 && m_ovf);
         check_ovf("rnd_ovf1", rsp1_ovf, rv1 && m_ovf);
         if (m_active && m_age == 0) begin
            check("rnd_add_x", add_x, m_x);
            check("rnd_add_y", add_y, m_y);
         end
         // Advance the model across the coming clock edge.
         if (!m_active) begin
            if (req0_valid || req1_valid) begin
               m_active = 1'b1; m_age = 0; m_g = w;
               m_x = w ? req1_x : req0_x;
               m_y = w ? req1_y : req0_y;
               sx = sval(m_x); sy = sval(m_y);
               m_sum = 8'(sx + sy);
               m_ovf = (sx + sy > (1 << (SIZE - 1)) - 1) || (sx + sy < -(1 << (SIZE - 1)));
            end
         end else if (m_age == 0) begin
            m_age = 1;
         end else if ((m_g && rsp1_ack) || (!m_g && rsp0_ack)) begin
            m_active = 1'b0; m_last = m_g;
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
